// File: rtl/stream_router_pkg.sv
// rtl/stream_router_pkg.sv - shared constants and helpers for the stream router
package stream_router_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_OUT    = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    function automatic logic addr_is_legal(input int addr, input int num_out);
        return addr < num_out;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/router_out_slot.sv
// rtl/router_out_slot.sv - single-entry valid/ready holding register for one output channel
module router_out_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_free
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_free  = !r_valid || i_ready;

    // A load beats a concurrent pop; an emptied slot drives zero on its lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_router.sv
// rtl/stream_router.sv - registered unicast/broadcast router with per-channel holding slots
module stream_router
    import stream_router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_OUT    = DEF_NUM_OUT,
    parameter int ADDR_WIDTH = $clog2(NUM_OUT),
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          bcast,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic [NUM_OUT-1:0]            dout_valid,
    input  logic [NUM_OUT-1:0]            dout_ready,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    logic [NUM_OUT-1:0]   w_slot_free;
    logic [NUM_OUT-1:0]   w_addr_onehot;
    logic [NUM_OUT-1:0]   w_load;
    logic                 w_addr_free;
    logic                 w_addr_legal;
    logic                 w_accept;
    logic                 w_drop;
    logic [CNT_WIDTH-1:0] r_drop_count;

    assign w_addr_legal = addr_is_legal(int'(addr), NUM_OUT);

    always_comb begin
        w_addr_free   = 1'b0;
        w_addr_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                w_addr_free      = w_slot_free[i];
                w_addr_onehot[i] = 1'b1;
            end
        end
    end

    // Illegal unicast addresses are always consumed so the producer never wedges.
    always_comb begin
        din_ready = 1'b1;
        if (bcast)
            din_ready = &w_slot_free;
        else if (w_addr_legal)
            din_ready = w_addr_free;
    end

    assign w_accept = din_valid && din_ready;
    assign w_drop   = w_accept && !bcast && !w_addr_legal;

    always_comb begin
        w_load = '0;
        if (w_accept)
            w_load = bcast ? {NUM_OUT{1'b1}} : w_addr_onehot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop_count <= '0;
        else if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}}))
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
    end

    assign drop_count = r_drop_count;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        router_out_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[g]),
            .i_data (din),
            .i_ready(dout_ready[g]),
            .o_data (dout[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .o_valid(dout_valid[g]),
            .o_free (w_slot_free[g])
        );
    end

endmodule
